// File: rtl/i2s_pkg.sv
// Shared types and width helpers for the I2S transmit path.
package i2s_pkg;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } i2s_slot_t;

    // Bits needed for a slot position 0 .. 2*width-1.
    function automatic int pos_bits(input int width);
        return $clog2(2 * width);
    endfunction

    // Divider counter width; at least one bit so clkdiv=1 still has a register.
    function automatic int cnt_bits(input int clkdiv);
        return (clkdiv > 1) ? $clog2(clkdiv) : 1;
    endfunction

endpackage

// File: rtl/i2s_transmitter_sck_gen.sv
// Bit-clock divider: sck toggles every clkdiv clk cycles, with a strobe on the
// clk cycle whose closing edge takes sck from 1 to 0.
module i2s_sck_gen
    import i2s_pkg::*;
#(
    parameter int clkdiv = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic sck_o,
    output logic sck_fall_o
);

    localparam int CW = cnt_bits(clkdiv);
    localparam logic [CW-1:0] TERM = CW'(clkdiv - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          term;

    always_comb begin
        term  = (cnt_q == TERM);
        cnt_d = term ? '0 : cnt_q + 1'b1;
        sck_d = term ? ~sck_q : sck_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck_o      = sck_q;
    assign sck_fall_o = term & sck_q;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: one-entry holding register feeding a frame shift register,
// serialised MSB first with the one-bit delay after each ws edge.
module i2s_transmitter
    import i2s_pkg::*;
#(
    parameter int width  = 16,
    parameter int clkdiv = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] in_left,
    input  logic [width-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sck,
    output logic             ws,
    output logic             sd,
    output logic             underrun
);

    localparam int PW = pos_bits(width);
    localparam logic [PW-1:0] P_LAST        = PW'(2 * width - 1);
    localparam logic [PW-1:0] P_FIRST_RIGHT = PW'(width);

    logic sck_fall;

    i2s_sck_gen #(
        .clkdiv(clkdiv)
    ) u_sck_gen (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .sck_o     (sck),
        .sck_fall_o(sck_fall)
    );

    logic [PW-1:0]        p_q, p_d;
    i2s_slot_t            ws_q, ws_d;
    logic                 sd_q, sd_d;
    logic                 hold_full_q, hold_full_d;
    logic [width-1:0]     hold_left_q, hold_left_d;
    logic [width-1:0]     hold_right_q, hold_right_d;
    logic [2*width-1:0]   act_q, act_d;
    logic                 rlsb_q, rlsb_d;
    logic                 underrun_q, underrun_d;

    logic transfer;
    logic frame_start;

    // in_ready comes straight from a register, so transfer never loops back
    // through in_valid combinationally.
    assign transfer    = in_valid && !hold_full_q;
    assign frame_start = sck_fall && (p_q == P_LAST);

    always_comb begin
        p_d          = p_q;
        ws_d         = ws_q;
        sd_d         = sd_q;
        act_d        = act_q;
        rlsb_d       = rlsb_q;
        underrun_d   = 1'b0;
        hold_full_d  = hold_full_q;
        hold_left_d  = hold_left_q;
        hold_right_d = hold_right_q;

        if (sck_fall) begin
            p_d  = frame_start ? '0 : p_q + 1'b1;
            ws_d = (p_d >= P_FIRST_RIGHT) ? SLOT_RIGHT : SLOT_LEFT;
            if (frame_start) begin
                // p=0 still carries the previous frame's right LSB.
                sd_d       = rlsb_q;
                act_d      = hold_full_q ? {hold_left_q, hold_right_q} : '0;
                rlsb_d     = hold_full_q ? hold_right_q[0] : 1'b0;
                underrun_d = !hold_full_q;
            end else begin
                sd_d  = act_q[2*width-1];
                act_d = {act_q[2*width-2:0], 1'b0};
            end
        end

        if (frame_start && hold_full_q) begin
            hold_full_d = 1'b0;
        end
        if (transfer) begin
            hold_full_d  = 1'b1;
            hold_left_d  = in_left;
            hold_right_d = in_right;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            p_q          <= P_LAST;
            ws_q         <= SLOT_RIGHT;
            sd_q         <= 1'b0;
            act_q        <= '0;
            rlsb_q       <= 1'b0;
            underrun_q   <= 1'b0;
            hold_full_q  <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
        end else begin
            p_q          <= p_d;
            ws_q         <= ws_d;
            sd_q         <= sd_d;
            act_q        <= act_d;
            rlsb_q       <= rlsb_d;
            underrun_q   <= underrun_d;
            hold_full_q  <= hold_full_d;
            hold_left_q  <= hold_left_d;
            hold_right_q <= hold_right_d;
        end
    end

    assign in_ready = !hold_full_q;
    assign ws       = ws_q;
    assign sd       = sd_q;
    assign underrun = underrun_q;

endmodule
